spi_frame_collector: RTL and testbench

- RTL frame collector that taps the SPI master pins (sclk, csn, mosi) in the system clock domain.
- For each chip-select frame, splits the serial stream into cmd/addr/dummy/data fields using the configured field lengths.
- Emits one packet per frame over a valid/ready interface; field layout mirrors the bench collector packet struct.
- Sits directly downstream of the SPI master pins and upstream of the scoreboard/packet consumer.

---
 rtl/spi_frame_collector_pkg.sv | 38 +++
 rtl/spi_frame_collector_if.sv | 27 ++
 rtl/spi_pin_sync.sv | 45 ++++
 rtl/spi_frame_collector.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_frame_collector.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_collector_pkg.sv
// Shared types for the SPI frame collector: FSM state enum, packet flag indices,
// default widths and the phase-sequencing helper.
package spi_frame_collector_pkg;

    localparam int DEF_CMD_W  = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam int FLAG_CMD  = 0;
    localparam int FLAG_ADDR = 1;
    localparam int FLAG_DATA = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE
    } state_e;

    // First phase after 'cur' whose latched length is non-zero; later
    // assignments override earlier ones, so the nearest phase wins.
    function automatic state_e next_phase(input state_e cur,
                                          input logic   cmd_nz,
                                          input logic   addr_nz,
                                          input logic   dummy_nz,
                                          input logic   data_nz);
        state_e nxt;
        nxt = ST_DONE;
        if (data_nz && (cur inside {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY})) nxt = ST_DATA;
        if (dummy_nz && (cur inside {ST_IDLE, ST_CMD, ST_ADDR}))          nxt = ST_DUMMY;
        if (addr_nz && (cur inside {ST_IDLE, ST_CMD}))                    nxt = ST_ADDR;
        if (cmd_nz && (cur == ST_IDLE))                                   nxt = ST_CMD;
        return nxt;
    endfunction

endpackage

// File: rtl/spi_frame_collector_if.sv
// Packet output bus of the SPI frame collector (master = collector, slave = consumer).
interface spi_frame_collector_if #(
    parameter int CMD_W  = 32,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a packet transfers on a cycle where pkt_valid && pkt_ready.
    // Once pkt_valid is high it and the payload stay stable until that transfer;
    // pkt_ready may be asserted at any time, including before pkt_valid.
    logic              pkt_valid;
    logic              pkt_ready;
    logic [CMD_W-1:0]  pkt_cmd;
    logic [ADDR_W-1:0] pkt_addr;
    logic [DATA_W-1:0] pkt_data;
    logic [2:0]        pkt_flag;
    logic [31:0]       pkt_bit_count;

    modport master (
        output pkt_valid, pkt_cmd, pkt_addr, pkt_data, pkt_flag, pkt_bit_count,
        input  pkt_ready
    );

    modport slave (
        input  pkt_valid, pkt_cmd, pkt_addr, pkt_data, pkt_flag, pkt_bit_count,
        output pkt_ready
    );
endinterface

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for the SPI pins plus edge pulses on the synchronized
// sclk and csn. Everything clears to 0, so a csn held low through reset shows no falling edge.
module spi_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sclk_i,
    input  logic csn_i,
    input  logic mosi_i,
    output logic csn_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic csn_rise_o,
    output logic csn_fall_o
);
    logic [1:0] sclk_q;
    logic [1:0] csn_q;
    logic [1:0] mosi_q;
    logic       sclk_prev_q;
    logic       csn_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= 2'b00;
            csn_q       <= 2'b00;
            mosi_q      <= 2'b00;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[0], sclk_i};
            csn_q       <= {csn_q[0], csn_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            sclk_prev_q <= sclk_q[1];
            csn_prev_q  <= csn_q[1];
        end
    end

    assign csn_o       = csn_q[1];
    assign mosi_o      = mosi_q[1];
    assign sclk_rise_o = sclk_q[1] & ~sclk_prev_q;
    assign sclk_fall_o = ~sclk_q[1] & sclk_prev_q;
    assign csn_rise_o  = csn_q[1] & ~csn_prev_q;
    assign csn_fall_o  = ~csn_q[1] & csn_prev_q;

endmodule

// File: rtl/spi_frame_collector.sv
// SPI frame collector: splits each chip-select frame into cmd/addr/dummy/data fields
// and emits one packet per frame. SPI_FRAME_COLLECTOR_SAMPLE_FALL_EN selects falling-edge capture.
module spi_frame_collector
    import spi_frame_collector_pkg::*;
#(
    parameter int CMD_W  = DEF_CMD_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_csn,
    input  logic        spi_mosi,
    input  logic [5:0]  cfg_cmd_len,
    input  logic [5:0]  cfg_addr_len,
    input  logic [15:0] cfg_dummy_len,
    input  logic [15:0] cfg_data_len,
    spi_frame_collector_if.master pkt,
    output logic        overflow,
    output state_e      dbg_state_o
);
    logic csn_s, mosi_s, sclk_rise, sclk_fall, csn_rise, csn_fall;
    logic sample;

    spi_pin_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .sclk_i      (spi_sclk),
        .csn_i       (spi_csn),
        .mosi_i      (spi_mosi),
        .csn_o       (csn_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .csn_rise_o  (csn_rise),
        .csn_fall_o  (csn_fall)
    );

`ifdef SPI_FRAME_COLLECTOR_SAMPLE_FALL_EN
    // A falling edge only counts once the frame has seen a rising edge.
    logic seen_rise_q, seen_rise_d;

    always_comb begin
        seen_rise_d = seen_rise_q;
        if (csn_fall) begin
            seen_rise_d = 1'b0;
        end else if (sclk_rise && !csn_s) begin
            seen_rise_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_rise_q <= 1'b0;
        end else begin
            seen_rise_q <= seen_rise_d;
        end
    end

    assign sample = sclk_fall && !csn_s && seen_rise_q;
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign sample = sclk_rise && !csn_s;
`endif

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d, cnt_inc, cur_len;
    logic [5:0]        cmd_len_q, cmd_len_d, addr_len_q, addr_len_d;
    logic [15:0]       dummy_len_q, dummy_len_d, data_len_q, data_len_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [2:0]        flag_q, flag_d;
    logic [31:0]       bit_cnt_q, bit_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [CMD_W-1:0]  out_cmd_q, out_cmd_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [2:0]        out_flag_q, out_flag_d;
    logic [31:0]       out_bit_cnt_q, out_bit_cnt_d;
    logic              overflow_q, overflow_d;
    state_e            phase_next;

    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        cur_len = 16'd0;
        case (state_q)
            ST_CMD:   cur_len = {10'd0, cmd_len_q};
            ST_ADDR:  cur_len = {10'd0, addr_len_q};
            ST_DUMMY: cur_len = dummy_len_q;
            ST_DATA:  cur_len = data_len_q;
            default:  cur_len = 16'd0;
        endcase
    end

    assign phase_next = next_phase(state_q, cmd_len_q != 6'd0, addr_len_q != 6'd0,
                                   dummy_len_q != 16'd0, data_len_q != 16'd0);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_len_d     = cmd_len_q;
        addr_len_d    = addr_len_q;
        dummy_len_d   = dummy_len_q;
        data_len_d    = data_len_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        data_d        = data_q;
        flag_d        = flag_q;
        bit_cnt_d     = bit_cnt_q;
        out_valid_d   = out_valid_q;
        out_cmd_d     = out_cmd_q;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        out_flag_d    = out_flag_q;
        out_bit_cnt_d = out_bit_cnt_q;
        overflow_d    = 1'b0;

        if (out_valid_q && pkt.pkt_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == ST_IDLE) begin
            if (csn_fall) begin
                cmd_len_d   = cfg_cmd_len;
                addr_len_d  = cfg_addr_len;
                dummy_len_d = cfg_dummy_len;
                data_len_d  = cfg_data_len;
                cnt_d       = 16'd0;
                cmd_d       = '0;
                addr_d      = '0;
                data_d      = '0;
                bit_cnt_d   = 32'd0;
                // Zero-length phases are skipped and count as already done.
                flag_d            = 3'b000;
                flag_d[FLAG_CMD]  = (cfg_cmd_len == 6'd0);
                flag_d[FLAG_ADDR] = (cfg_addr_len == 6'd0);
                flag_d[FLAG_DATA] = (cfg_data_len == 16'd0);
                state_d = next_phase(ST_IDLE, cfg_cmd_len != 6'd0, cfg_addr_len != 6'd0,
                                     cfg_dummy_len != 16'd0, cfg_data_len != 16'd0);
            end
        end else if (csn_rise) begin
            state_d = ST_IDLE;
            if (bit_cnt_q != 32'd0) begin
                if (!out_valid_q || pkt.pkt_ready) begin
                    out_valid_d   = 1'b1;
                    out_cmd_d     = cmd_q;
                    out_addr_d    = addr_q;
                    out_data_d    = data_q;
                    out_flag_d    = flag_q;
                    out_bit_cnt_d = bit_cnt_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (sample) begin
            if (bit_cnt_q != 32'hFFFF_FFFF) begin
                bit_cnt_d = bit_cnt_q + 32'd1;
            end
            case (state_q)
                ST_CMD:   cmd_d  = {cmd_q[CMD_W-2:0], mosi_s};
                ST_ADDR:  addr_d = {addr_q[ADDR_W-2:0], mosi_s};
                ST_DATA:  data_d = {data_q[DATA_W-2:0], mosi_s};
                default:  ;
            endcase
            if (state_q != ST_DONE) begin
                if (cnt_inc == cur_len) begin
                    cnt_d   = 16'd0;
                    state_d = phase_next;
                    case (state_q)
                        ST_CMD:  flag_d[FLAG_CMD]  = 1'b1;
                        ST_ADDR: flag_d[FLAG_ADDR] = 1'b1;
                        ST_DATA: flag_d[FLAG_DATA] = 1'b1;
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            cmd_len_q     <= 6'd0;
            addr_len_q    <= 6'd0;
            dummy_len_q   <= 16'd0;
            data_len_q    <= 16'd0;
            cmd_q         <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            flag_q        <= 3'b000;
            bit_cnt_q     <= 32'd0;
            out_valid_q   <= 1'b0;
            out_cmd_q     <= '0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            out_flag_q    <= 3'b000;
            out_bit_cnt_q <= 32'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_len_q     <= cmd_len_d;
            addr_len_q    <= addr_len_d;
            dummy_len_q   <= dummy_len_d;
            data_len_q    <= data_len_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            flag_q        <= flag_d;
            bit_cnt_q     <= bit_cnt_d;
            out_valid_q   <= out_valid_d;
            out_cmd_q     <= out_cmd_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            out_flag_q    <= out_flag_d;
            out_bit_cnt_q <= out_bit_cnt_d;
            overflow_q    <= overflow_d;
        end
    end

    assign pkt.pkt_valid     = out_valid_q;
    assign pkt.pkt_cmd       = out_cmd_q;
    assign pkt.pkt_addr      = out_addr_q;
    assign pkt.pkt_data      = out_data_q;
    assign pkt.pkt_flag      = out_flag_q;
    assign pkt.pkt_bit_count = out_bit_cnt_q;
    assign overflow          = overflow_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_spi_frame_collector.sv
// Directed bench for spi_frame_collector: bit-banged SPI frames, expected packets
// queued by hand and compared field by field.
module tb_spi_frame_collector;
    import spi_frame_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic [5:0]  cfg_cmd_len = 6'd0;
    logic [5:0]  cfg_addr_len = 6'd0;
    logic [15:0] cfg_dummy_len = 16'd0;
    logic [15:0] cfg_data_len = 16'd0;
    logic        overflow;
    state_e      dbg_state;

    spi_frame_collector_if #(.CMD_W(32), .ADDR_W(32), .DATA_W(32)) pkt_if ();

    spi_frame_collector dut (
        .clk           (clk),
        .rst           (rst),
        .spi_sclk      (spi_sclk),
        .spi_csn       (spi_csn),
        .spi_mosi      (spi_mosi),
        .cfg_cmd_len   (cfg_cmd_len),
        .cfg_addr_len  (cfg_addr_len),
        .cfg_dummy_len (cfg_dummy_len),
        .cfg_data_len  (cfg_data_len),
        .pkt           (pkt_if.master),
        .overflow      (overflow),
        .dbg_state_o   (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int vld_rises = 0;
    int ovf_cnt = 0;
    logic vld_prev = 1'b0;

    always @(negedge clk) begin
        if (pkt_if.pkt_valid && !vld_prev) vld_rises++;
        vld_prev = pkt_if.pkt_valid;
        if (overflow) ovf_cnt++;
    end

    // expected packet: {cmd[32], addr[32], data[32], flag[3], bit_count[32]}
    logic [130:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f, input logic [31:0] n);
        exp_q.push_back({c, a, d, f, n});
    endtask

    // driver tasks
    task automatic set_cfg(input int c, input int a, input int dm, input int d);
        cfg_cmd_len   = 6'(c);
        cfg_addr_len  = 6'(a);
        cfg_dummy_len = 16'(dm);
        cfg_data_len  = 16'(d);
    endtask

    task automatic start_frame();
        repeat (6) @(negedge clk);
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (4) @(negedge clk);
        spi_csn = 1'b1;
    endtask

    task automatic spi_bit(input logic b);
        @(negedge clk);
        spi_mosi = b;
        repeat (3) @(negedge clk);
        spi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
    endtask

    // scoreboard: wait (bounded) for a packet and compare against the queue head
    task automatic collect_pkt(input string tag);
        int waited;
        logic [130:0] e;
        waited = 0;
        while (!pkt_if.pkt_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_valid"}, 64'(pkt_if.pkt_valid), 64'd1);
        e = exp_q.pop_front();
        check({tag, "_cmd"},  64'(pkt_if.pkt_cmd),       64'(e[130:99]));
        check({tag, "_addr"}, 64'(pkt_if.pkt_addr),      64'(e[98:67]));
        check({tag, "_data"}, 64'(pkt_if.pkt_data),      64'(e[66:35]));
        check({tag, "_flag"}, 64'(pkt_if.pkt_flag),      64'(e[34:32]));
        check({tag, "_bits"}, 64'(pkt_if.pkt_bit_count), 64'(e[31:0]));
    endtask

    task automatic full_frame(input string tag);
        set_cfg(8, 24, 0, 32);
        push_exp(32'h0B, 32'h123456, 32'hDEADBEEF, 3'b111, 32'd64);
        start_frame();
        send_bits(64'h0B, 8);
        send_bits(64'h123456, 24);
        send_bits(64'hDEADBEEF, 32);
        end_frame();
        collect_pkt(tag);
    endtask

    int v0;
    int o0;

    initial begin
        pkt_if.pkt_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 64'(pkt_if.pkt_valid), 64'd0);
        check("rst_ovf",   64'(overflow), 64'd0);
        check("rst_cmd",   64'(pkt_if.pkt_cmd), 64'd0);
        check("rst_addr",  64'(pkt_if.pkt_addr), 64'd0);
        check("rst_data",  64'(pkt_if.pkt_data), 64'd0);
        check("rst_flag",  64'(pkt_if.pkt_flag), 64'd0);
        check("rst_bits",  64'(pkt_if.pkt_bit_count), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));

        full_frame("full");
        @(negedge clk);
        check("full_accepted", 64'(pkt_if.pkt_valid), 64'd0);

        set_cfg(8, 24, 0, 32);
        push_exp(32'hA5, 32'hABC, 32'h0, 3'b001, 32'd20);
        start_frame();
        send_bits(64'hA5, 8);
        send_bits(64'hABC, 12);
        end_frame();
        collect_pkt("trunc");

        set_cfg(8, 0, 8, 16);
        push_exp(32'h9F, 32'h0, 32'h1234, 3'b111, 32'd32);
        start_frame();
        send_bits(64'h9F, 8);
        send_bits(64'hFF, 8);
        send_bits(64'h1234, 16);
        end_frame();
        collect_pkt("dummy");

        set_cfg(8, 0, 0, 40);
        push_exp(32'h3C, 32'h0, 32'h23456789, 3'b111, 32'd48);
        start_frame();
        send_bits(64'h3C, 8);
        send_bits(64'h01_2345_6789, 40);
        end_frame();
        collect_pkt("long");

        set_cfg(0, 0, 0, 0);
        push_exp(32'h0, 32'h0, 32'h0, 3'b111, 32'd4);
        start_frame();
        send_bits(64'hA, 4);
        end_frame();
        collect_pkt("allzero");

        // frame without sclk edges is dropped silently
        repeat (4) @(negedge clk);
        v0 = vld_rises;
        start_frame();
        end_frame();
        repeat (20) @(negedge clk);
        check("empty_no_pkt", 64'(vld_rises), 64'(v0));

        // backpressure: second frame overflows, first packet held
        pkt_if.pkt_ready = 1'b0;
        set_cfg(0, 0, 0, 8);
        push_exp(32'h0, 32'h0, 32'h11, 3'b111, 32'd8);
        start_frame();
        send_bits(64'h11, 8);
        end_frame();
        collect_pkt("bp1");
        o0 = ovf_cnt;
        start_frame();
        check("bp_state_data", 64'(dbg_state), 64'(ST_DATA));
        send_bits(64'h22, 8);
        end_frame();
        repeat (20) @(negedge clk);
        check("bp_ovf_once", 64'(ovf_cnt - o0), 64'd1);
        check("bp_hold_valid", 64'(pkt_if.pkt_valid), 64'd1);
        check("bp_hold_data", 64'(pkt_if.pkt_data), 64'h11);
        pkt_if.pkt_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", 64'(pkt_if.pkt_valid), 64'd0);

        // reset mid-frame: csn stays low, so the rest of the frame is ignored
        set_cfg(8, 24, 0, 32);
        v0 = vld_rises;
        start_frame();
        send_bits(64'h0B, 8);
        send_bits(64'h2, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_bits(64'h00AB_CDEF_0123_4567, 54);
        check("rstmid_idle", 64'(dbg_state), 64'(ST_IDLE));
        end_frame();
        repeat (30) @(negedge clk);
        check("rstmid_no_pkt", 64'(vld_rises), 64'(v0));
        full_frame("after_rst");

        repeat (5) @(negedge clk);
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
